// File: rtl/shifter_pkg.sv
// shifter_pkg: shift-op encoding and per-stage control fields shared by the barrel shifter.
package shifter_pkg;
  typedef enum logic [1:0] {
    SHOP_ROR = 2'b00,
    SHOP_LSL = 2'b01,
    SHOP_LSR = 2'b10,
    SHOP_ASR = 2'b11
  } sh_op_e;
  typedef struct packed {
    logic   valid;
    logic   sat;
    logic   sticky;
    sh_op_e op;
  } stage_ctrl_t;
endpackage

// File: rtl/barrel_shift_stage.sv
// barrel_shift_stage: combinational shift-by-SH step; sticky accumulates only with SHIFTER_STICKY_EN.
module barrel_shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SH = 1
) (
  input  logic [WIDTH-1:0] data,
  input  sh_op_e           op,
  input  logic             en,
  input  logic             sticky,
  output logic [WIDTH-1:0] result,
  output logic             sticky_acc
);
  logic [WIDTH-1:0] shifted;
  always_comb
    shifted = op == SHOP_ROR ? {data[SH-1:0], data[WIDTH-1:SH]} :
              op == SHOP_LSL ? {data[WIDTH-SH-1:0], {SH{1'b0}}} :
              op == SHOP_LSR ? {{SH{1'b0}}, data[WIDTH-1:SH]} :
                               {{SH{data[WIDTH-1]}}, data[WIDTH-1:SH]};
  assign result = en ? shifted : data;
`ifdef SHIFTER_STICKY_EN
  // only right shifts lose low-order bits that matter for rounding
  assign sticky_acc = sticky | (en & op[1] & |data[SH-1:0]);
`else
  logic unused_sticky;
  assign unused_sticky = sticky;
  assign sticky_acc = 1'b0;
`endif
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: PIPE-register ROR/LSL/LSR/ASR shifter with valid/ready flow control.
// Define SHIFTER_STICKY_EN to produce the sticky bit; otherwise out_sticky stays 0.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PIPE = 2,
  parameter int TAG_W = 4,
  localparam int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W:0]   in_amt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky,
  output logic [TAG_W-1:0] out_tag
);
  localparam int GRP = (LOG2W + PIPE - 1) / PIPE;
  typedef struct packed {
    stage_ctrl_t      ctrl;
    logic [LOG2W-1:0] amt;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
  } stage_t;
  stage_t head;
  stage_t [PIPE-1:0] nxt, regs;
  logic [PIPE-1:0] adv;
  logic blk0, unused_regs;
  // saturated LSL/LSR/ASR resolve to their fill value up front; later stages then stay disabled
  always_comb begin
    blk0 = in_amt[LOG2W] & (in_op != SHOP_ROR);
    head.ctrl.valid = in_valid;
    head.ctrl.sat = in_amt[LOG2W];
    head.ctrl.op = sh_op_e'(in_op);
    head.amt = in_amt[LOG2W-1:0];
    head.tag = in_tag;
    head.data = !blk0 ? in_data : in_op == SHOP_ASR ? {WIDTH{in_data[WIDTH-1]}} : '0;
`ifdef SHIFTER_STICKY_EN
    head.ctrl.sticky = blk0 & in_op[1] & |in_data;
`else
    head.ctrl.sticky = 1'b0;
`endif
  end
  for (genvar g = 0; g < PIPE; g++) begin : grp
    localparam int LO = g * GRP;
    localparam int HI = (g + 1) * GRP < LOG2W ? (g + 1) * GRP : LOG2W;
    localparam int N = HI > LO ? HI - LO : 0;
    stage_t src;
    logic blk;
    if (g == 0) begin : first
      assign src = head;
    end else begin : chain
      assign src = regs[g-1];
    end
    assign blk = src.ctrl.sat & (src.ctrl.op != SHOP_ROR);
    for (genvar j = 0; j < N; j++) begin : stg
      logic [WIDTH-1:0] prev, q;
      logic prev_s, s;
      if (j == 0) begin : f
        assign prev = src.data;
        assign prev_s = src.ctrl.sticky;
      end else begin : c
        assign prev = stg[j-1].q;
        assign prev_s = stg[j-1].s;
      end
      barrel_shift_stage #(.WIDTH(WIDTH), .SH(1 << (LO + j))) u_stage (
        .data(prev),
        .op(src.ctrl.op),
        .en(src.amt[LO+j] & !blk),
        .sticky(prev_s),
        .result(q),
        .sticky_acc(s)
      );
    end
    if (N == 0) begin : pass
      assign nxt[g] = src;
    end else begin : shift
      assign nxt[g] = {src.ctrl.valid, src.ctrl.sat, stg[N-1].s, src.ctrl.op, src.amt, src.tag, stg[N-1].q};
    end
  end
  // a stage moves when it is empty or the stage after it is moving
  always_comb begin
    adv[PIPE-1] = !regs[PIPE-1].ctrl.valid | out_ready;
    for (int k = PIPE - 2; k >= 0; k--) adv[k] = !regs[k].ctrl.valid | adv[k+1];
  end
  always_ff @(posedge clk)
    for (int k = 0; k < PIPE; k++)
      if (rst) regs[k] <= '0;
      else if (adv[k]) regs[k] <= nxt[k];
  assign in_ready = adv[0];
  assign out_valid = regs[PIPE-1].ctrl.valid;
  assign out_data = regs[PIPE-1].data;
  assign out_sticky = regs[PIPE-1].ctrl.sticky;
  assign out_tag = regs[PIPE-1].tag;
  assign unused_regs = ^regs[PIPE-1];
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: scoreboard bench, WIDTH=16 PIPE=2 TAG_W=4; sticky expectations track SHIFTER_STICKY_EN.
module tb_pipelined_barrel_shifter;
  localparam int W = 16, P = 2, T = 4;
`ifdef SHIFTER_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_sticky;
  logic [W-1:0] in_data, out_data;
  logic [4:0] in_amt;
  logic [1:0] in_op;
  logic [T-1:0] in_tag, out_tag;
  typedef struct packed {
    logic [T-1:0] tag;
    logic         sticky;
    logic [W-1:0] data;
  } exp_t;
  exp_t q[$];
  exp_t front;
  int total = 0, bad = 0;
  logic rand_rdy = 1'b0;
  logic hold = 1'b0;
  logic [W+T:0] held;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(W), .PIPE(P), .TAG_W(T)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sticky(out_sticky), .out_tag(out_tag)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] v, input logic s, input logic [T-1:0] t);
    mk = '{tag: t, sticky: s & STK, data: v};
  endfunction

  function automatic exp_t model(input logic [W-1:0] d, input logic [4:0] a, input logic [1:0] op, input logic [T-1:0] t);
    exp_t e;
    int n;
    n = int'(a);
    e.tag = t;
    e.sticky = 1'b0;
    case (op)
      2'b00: for (int i = 0; i < W; i++) e.data[i] = d[(i + n) % W];
      2'b01: e.data = n >= W ? '0 : d << n;
      2'b10: e.data = n >= W ? '0 : d >> n;
      default: e.data = n >= W ? {W{d[W-1]}} : W'($signed(d) >>> n);
    endcase
    if (op[1]) for (int i = 0; i < W; i++) if (i < n) e.sticky = e.sticky | d[i];
    e.sticky = e.sticky & STK;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [W-1:0] d, input logic [4:0] a, input logic [1:0] op, input logic [T-1:0] t, input exp_t e);
    bit done = 1'b0;
    in_valid = 1'b1; in_data = d; in_amt = a; in_op = op; in_tag = t;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        done = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    chk("accepted", 32'(done), 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && q.size() != 0; k++) step();
    chk("drain", q.size(), 0);
  endtask

  task automatic load_bp(input int n);
    in_valid = n <= 4;
    in_data = 16'hA5C3 ^ 16'(n);
    in_amt = 5'(n * 5);
    in_op = 2'(n);
    in_tag = 4'(n);
  endtask

  // scoreboard pop plus stability of a stalled output
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {out_tag, out_sticky, out_data}, held);
      end
      hold = out_valid & !out_ready;
      held = {out_tag, out_sticky, out_data};
      if (out_valid && out_ready) begin
        chk("scoreboard_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          front = q.pop_front();
          chk("data", out_data, front.data);
          chk("sticky", out_sticky, front.sticky);
          chk("tag", out_tag, front.tag);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rd;
    logic [4:0] ra;
    logic [1:0] ro;
    logic [T-1:0] rt;
    logic [W+T-1:0] held_bp;
    int nacc, nb;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; in_tag = '0; out_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_sticky", out_sticky, 0);
    chk("rst_in_ready", in_ready, 1);
    step();
    // latency: result visible two edges after the accepting edge
    send(16'h1234, 5'd4, 2'b00, 4'd1, mk(16'h4123, 1'b0, 4'd1));
    @(negedge clk);
    chk("lat_edge1_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_edge2_valid", out_valid, 1);
    chk("lat_edge2_data", out_data, 16'h4123);
    drain();
    send(16'h1234, 5'd20, 2'b00, 4'd2, mk(16'h4123, 1'b0, 4'd2));
    send(16'h0001, 5'd15, 2'b01, 4'd3, mk(16'h8000, 1'b0, 4'd3));
    send(16'h0001, 5'd16, 2'b01, 4'd4, mk(16'h0000, 1'b0, 4'd4));
    send(16'h0001, 5'd0, 2'b01, 4'd5, mk(16'h0001, 1'b0, 4'd5));
    send(16'h00F0, 5'd4, 2'b10, 4'd6, mk(16'h000F, 1'b0, 4'd6));
    send(16'h00F0, 5'd5, 2'b10, 4'd7, mk(16'h0007, 1'b1, 4'd7));
    send(16'h8001, 5'd1, 2'b11, 4'd8, mk(16'hC000, 1'b1, 4'd8));
    send(16'h8000, 5'd31, 2'b11, 4'd9, mk(16'hFFFF, 1'b1, 4'd9));
    send(16'h8421, 5'd0, 2'b11, 4'd10, mk(16'h8421, 1'b0, 4'd10));
    send(16'hBEEF, 5'd0, 2'b00, 4'd11, mk(16'hBEEF, 1'b0, 4'd11));
    send(16'hFFFF, 5'd16, 2'b10, 4'd12, mk(16'h0000, 1'b1, 4'd12));
    drain();
    // backpressure: stalled output, four beats offered, two fit
    out_ready = 1'b0;
    nacc = 0;
    nb = 1;
    load_bp(nb);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) held_bp = {out_tag, out_data};
      if (c > 2) chk("bp_stable", {out_tag, out_data}, held_bp);
      if (c == 5) chk("bp_in_ready_low", in_ready, 0);
      if (in_valid && in_ready) begin
        q.push_back(model(in_data, in_amt, in_op, in_tag));
        nacc++;
        nb++;
      end
      step();
      load_bp(nb);
    end
    chk("bp_accepted", nacc, 2);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_release_valid", out_valid, 1);
      chk("bp_release_tag", out_tag, c + 1);
      if (in_valid && in_ready) begin
        q.push_back(model(in_data, in_amt, in_op, in_tag));
        nb++;
      end
      step();
      load_bp(nb);
    end
    in_valid = 1'b0;
    drain();
    // reset with two beats in flight
    send(16'h1111, 5'd1, 2'b01, 4'd5, model(16'h1111, 5'd1, 2'b01, 4'd5));
    send(16'h2222, 5'd2, 2'b10, 4'd6, model(16'h2222, 5'd2, 2'b10, 4'd6));
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 1);
    step();
    send(16'h00FF, 5'd4, 2'b01, 4'd7, mk(16'h0FF0, 1'b0, 4'd7));
    drain();
    // full-throughput random traffic
    for (int n = 0; n < 1000; n++) begin
      in_valid = 1'b1;
      in_data = 16'($urandom);
      in_amt = 5'($urandom_range(0, 31));
      in_op = 2'($urandom_range(0, 3));
      in_tag = 4'($urandom);
      @(negedge clk);
      chk("rand_in_ready", in_ready, 1);
      if (in_ready) q.push_back(model(in_data, in_amt, in_op, in_tag));
      step();
    end
    in_valid = 1'b0;
    drain();
    // random traffic under random backpressure and input gaps
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      rd = 16'($urandom);
      ra = 5'($urandom_range(0, 31));
      ro = 2'($urandom_range(0, 3));
      rt = 4'($urandom);
      if ($urandom_range(0, 3) == 0) step();
      send(rd, ra, ro, rt, model(rd, ra, ro, rt));
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised successor to the fixed 16-bit rotate-only barrel shifter.
- Supports rotate right, logical left, logical right and arithmetic right.
- Amount may reach WIDTH; shift is split into log2 stages with configurable pipeline registers and valid/ready flow control.
- Sits in the FPU datapath for mantissa alignment/normalisation. Optionally produces a sticky bit for rounding.

Parameters:
- WIDTH, 16, data width; power of two, 4..64.
- PIPE, 2, number of register boundaries (latency in cycles), 1..log2(WIDTH).
- TAG_W, 4, width of sideband tag carried alongside data, ≥1.
- Derived localparam LOG2W = log2(WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock; synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  WIDTH  value to shift.
- in_amt  in  LOG2W+1  shift amount, 0..2*WIDTH-1.
- in_op  in  2  00 ROR, 01 LSL, 10 LSR, 11 ASR.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  WIDTH  shifted result.
- out_sticky  out  1  OR of bits shifted out (see Optional Feature).
- out_tag  out  TAG_W  tag of this result.

Behaviour:
- Transfer occurs on a rising edge where valid & ready on the same interface.
- Arithmetic rules:
  - ROR uses in_amt mod WIDTH; bit i of result = in_data[(i+amt) mod WIDTH], identical to the legacy block.
  - LSL/LSR zero-fill.
  - ASR fills with in_data[WIDTH-1].
  - amt ≥ WIDTH gives 0 for LSL/LSR and all-sign for ASR.
  - amt = 0 passes data unchanged for every op.
- Datapath: LOG2W combinational stages, shifting by 1,2,4,… (LSB amount bit first).
  - Stages are grouped into PIPE groups of ceil(LOG2W/PIPE); trailing group may be smaller.
  - A register follows each group; the last register drives the out_* ports.
  - Each register holds a valid bit, partial data, remaining amount bits, op, tag and partial sticky.
  - The saturation flag (amt ≥ WIDTH) is computed in group 0 and carried.
- Latency: a beat accepted at edge N appears on out_* during cycle N+PIPE-1 if no stall, i.e. visible PIPE edges after entry counting the entry edge.
- Flow control is per-stage and bubble-collapsing:
  - stage k advances when it is empty, or when stage k+1 is advancing/empty.
  - The last stage advances when out_ready or !out_valid.
  - in_ready = stage-0 advance condition.
  - Full throughput is one beat per cycle when out_ready=1.
  - With out_ready held low the pipe holds exactly PIPE beats; in_ready deasserts only when all are full.
- out_* are stable while out_valid & !out_ready. No beat is dropped or duplicated; order is preserved.
- Simultaneous accept and emit on a full pipe is permitted; in_ready is combinational from out_ready.
- Reset:
  - All valid bits and every data/tag/sticky register go to 0, so out_valid=0, out_data=0, out_sticky=0, out_tag=0.
  - in_ready=1 in the cycle after rst deasserts.
  - Reset mid-operation discards in-flight beats.

Optional Feature:
- Macro SHIFTER_STICKY_EN.
- Defined:
  - For LSR/ASR, out_sticky = OR of in_data bits at positions < min(amt,WIDTH).
  - For ROR/LSL, out_sticky = 0.
  - Accumulated per stage.
- Undefined: sticky logic and registers are removed; out_sticky tied 0. The port always exists.

Decomposition:
- Package shifter_pkg holds:
  - op encoding constants SHOP_ROR=2'b00, SHOP_LSL=2'b01, SHOP_LSR=2'b10, SHOP_ASR=2'b11;
  - a stage-register struct typedef parametrised via localparams.
- One sub-module, barrel_shift_stage: purely combinational single stage (shift by 2^k), with data, op, enable bit and sticky in/out. It is instantiated LOG2W times via generate.

Test Plan (WIDTH=16, PIPE=2, macro defined unless noted):
- ROR 0x1234 amt 4 -> 0x4123, out_valid 2 edges after accept. ROR amt 20 -> 0x4123.
- LSL 0x0001 amt 15 -> 0x8000; amt 16 -> 0x0000; amt 0 -> 0x0001.
- LSR 0x00F0 amt 4 -> 0x000F sticky 0; amt 5 -> 0x0007 sticky 1. ASR 0x8001 amt 1 -> 0xC000 sticky 1; ASR 0x8000 amt 31 -> 0xFFFF.
- Backpressure:
  - out_ready=0 for 6 cycles while 4 back-to-back beats (tags 1..4) are offered;
  - in_ready falls after 2 accepted, out_data stable;
  - on release, tags emerge 1,2,3,4 with no gaps.
- rst asserted for one cycle with 2 beats in flight -> next cycle out_valid=0, out_data=0; a subsequent beat completes normally.
- 1000 random ops/amounts with out_ready=1 -> in_ready stays 1, results match reference model. Rerun with macro undefined: out_sticky always 0.
